// File: rtl/tx_pkg.sv
// Shared defaults and types for the CDL transmit serializer.
package tx_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned STUFF_LEN_DEF = 6;
  localparam logic        IDLE_BIT_DEF  = 1'b1;
  localparam int unsigned ONES_W_DEF    = $clog2(STUFF_LEN_DEF + 1);

  // What a strobe does this bit time, in priority order.
  typedef enum logic [1:0] {
    ACT_IDLE  = 2'd0,
    ACT_STUFF = 2'd1,
    ACT_SHIFT = 2'd2,
    ACT_LOAD  = 2'd3
  } strobe_act_e;

endpackage

// File: rtl/tx_hold_buf.sv
// One-entry holding register between the byte handshake and the shifter.
module tx_hold_buf
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] hold_data,
  output logic              hold_full,
  output logic              hold_full_nxt_c
);

  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_full_q, hold_full_d;
  logic              tx_ready_q, tx_ready_d;
  logic              accept;

  // Accept fills the entry; a pop from the shifter empties it (never both at once).
  always_comb begin
    hold_data_d = hold_data_q;
    hold_full_d = hold_full_q;
    accept      = tx_valid && tx_ready_q;
    if (accept) begin
      hold_data_d = tx_data;
      hold_full_d = 1'b1;
    end else if (pop) begin
      hold_full_d = 1'b0;
    end
    tx_ready_d = !hold_full_d;
  end

  // Holding register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      tx_ready_q  <= 1'b1;
    end else begin
      hold_data_q <= hold_data_d;
      hold_full_q <= hold_full_d;
      tx_ready_q  <= tx_ready_d;
    end
  end

  assign tx_ready        = tx_ready_q;
  assign hold_data       = hold_data_q;
  assign hold_full       = hold_full_q;
  assign hold_full_nxt_c = hold_full_d;

endmodule

// File: rtl/tx_stuff_serializer.sv
// LSB-first byte serializer with bit stuffing, feeding the NRZI encoder.
module tx_stuff_serializer
  import tx_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEF,
  parameter logic        IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              clear_stuff,
  output logic              d_orig,
  output logic              byte_done,
  output logic              stuffing,
  output logic              idle
);

  localparam int unsigned BCNT_W = $clog2(DATA_W + 1);
  localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);
  localparam logic [BCNT_W-1:0] BCNT_EMPTY = BCNT_W'(DATA_W);
  localparam logic [ONES_W-1:0] ONES_MAX   = ONES_W'(STUFF_LEN);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [ONES_W-1:0] ones_cnt_q, ones_cnt_d;
  logic              d_orig_q, d_orig_d;
  logic              stuffing_q, stuffing_d;
  logic              byte_done_q, byte_done_d;
  logic              idle_q, idle_d;

  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic              hold_full_nxt;
  logic              pop;
  logic [DATA_W-1:0] src;
  strobe_act_e       act;

  tx_hold_buf #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk             (clk),
    .rst             (rst),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .pop             (pop),
    .hold_data       (hold_data),
    .hold_full       (hold_full),
    .hold_full_nxt_c (hold_full_nxt)
  );

  // Per-strobe bit selection: stuff, shift, load-and-shift, or idle level.
  always_comb begin
    sr_d        = sr_q;
    bit_cnt_d   = bit_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    d_orig_d    = d_orig_q;
    stuffing_d  = stuffing_q;
    byte_done_d = 1'b0;
    pop         = 1'b0;
    src         = sr_q;
    act         = ACT_IDLE;

    if (ones_cnt_q == ONES_MAX) begin
      act = ACT_STUFF;
    end else if (bit_cnt_q != BCNT_EMPTY) begin
      act = ACT_SHIFT;
    end else if (hold_full) begin
      act = ACT_LOAD;
    end

    if (strobe) begin
      unique case (act)
        ACT_STUFF: begin
          d_orig_d   = 1'b0;
          stuffing_d = 1'b1;
          ones_cnt_d = '0;
        end
        ACT_SHIFT, ACT_LOAD: begin
          pop         = (act == ACT_LOAD);
          src         = pop ? hold_data : sr_q;
          d_orig_d    = src[0];
          sr_d        = src >> 1;
          bit_cnt_d   = pop ? BCNT_W'(1) : bit_cnt_q + BCNT_W'(1);
          stuffing_d  = 1'b0;
          ones_cnt_d  = src[0] ? ones_cnt_q + ONES_W'(1) : '0;
          byte_done_d = (bit_cnt_d == BCNT_EMPTY);
        end
        default: begin
          d_orig_d   = IDLE_BIT;
          stuffing_d = 1'b0;
        end
      endcase
    end

    // Packet-boundary clear only while nothing is in flight.
    if (clear_stuff && idle_q) begin
      ones_cnt_d = '0;
    end

    idle_d = (bit_cnt_d == BCNT_EMPTY) && !hold_full_nxt && (ones_cnt_d != ONES_MAX);
  end

  // Serializer state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= '0;
      bit_cnt_q   <= BCNT_EMPTY;
      ones_cnt_q  <= '0;
      d_orig_q    <= IDLE_BIT;
      stuffing_q  <= 1'b0;
      byte_done_q <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      d_orig_q    <= d_orig_d;
      stuffing_q  <= stuffing_d;
      byte_done_q <= byte_done_d;
      idle_q      <= idle_d;
    end
  end

  assign d_orig    = d_orig_q;
  assign stuffing  = stuffing_q;
  assign byte_done = byte_done_q;
  assign idle      = idle_q;

endmodule

// File: doc/tx_stuff_serializer.md
Name: tx_stuff_serializer

Overview:
- Byte-to-bit serializer with USB-style bit stuffing for the CDL transmit path.
- Accepts parallel bytes over a valid/ready handshake through a one-entry holding buffer, and emits bits LSB-first, one per strobe pulse.
- Inserts a 0 after every STUFF_LEN consecutive 1s.
- Drives d_orig of the downstream NRZI encoder; d_orig is stable for a full bit time.

Parameters:
- DATA_W, 8, byte width.
- STUFF_LEN, 6, consecutive 1s that force a stuffed 0.
- IDLE_BIT, 1'b1, d_orig level when no bits are pending.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- strobe  in  1  one-cycle pulse per bit time; d_orig updates only on cycles where strobe=1.
- tx_data  in  DATA_W  byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding buffer empty; a byte is accepted when tx_valid && tx_ready.
- clear_stuff  in  1  zero the ones counter at packet boundary.
- d_orig  out  1  serial bit to the encoder.
- byte_done  out  1  one-cycle pulse on the strobe cycle that emits the last data bit of a byte.
- stuffing  out  1  high for the bit time in which d_orig carries a stuffed 0.
- idle  out  1  no data bits and no stuff bit pending.

Behaviour:
- Reset (rst=1 at a clk edge):
  - d_orig=IDLE_BIT, tx_ready=1, byte_done=0, stuffing=0, idle=1.
  - Shift register empty, hold empty, ones_cnt=0.
  - Reset takes priority over every other input, including a reset that arrives mid-byte: the partial byte and the held byte are discarded.
- State is {shift reg, bit_cnt 0..DATA_W where DATA_W=empty, hold reg + hold_full, ones_cnt 0..STUFF_LEN}.
- Accept: tx_valid && tx_ready stores tx_data into hold and sets hold_full. tx_ready = !hold_full (registered).
- Non-strobe cycles: only accept and clear_stuff act; d_orig holds its value.
- On a strobe cycle, evaluate in this priority order, using register values before the edge:
  1. ones_cnt==STUFF_LEN: d_orig<=0, stuffing<=1, ones_cnt<=0. Shift register unchanged. This applies even if no data is pending, so a trailing stuff bit is always sent.
  2. Else if bit_cnt<DATA_W: d_orig<=sr[0], shift right, bit_cnt++, stuffing<=0. ones_cnt <= sr[0] ? ones_cnt+1 : 0. byte_done<=1 if this was bit DATA_W-1.
  3. Else if hold_full: load hold into shift register, emit bit 0 in the same strobe (same rules as case 2), hold_full<=0. tx_ready rises the next cycle, so there is no bit-time gap between bytes.
  4. Else: d_orig<=IDLE_BIT, stuffing<=0.
- Latency: a byte accepted at cycle t first appears on d_orig at the first strobe strictly after t. A strobe in cycle t does not see the byte accepted in cycle t.
- byte_done and stuffing:
  - byte_done is high only in the cycle after its strobe edge (one-cycle pulse).
  - stuffing stays registered until the next strobe.
- ones_cnt persists across byte boundaries and across idle gaps; it is cleared only by a stuff bit, a 0 data bit, clear_stuff, or rst.
- clear_stuff:
  - Honoured only when idle=1; ignored otherwise.
  - If asserted together with a strobe while idle, clear wins (no stuff bit is emitted).
- idle = (bit_cnt==DATA_W) && !hold_full && (ones_cnt!=STUFF_LEN).
- Simultaneous accept and strobe with the hold buffer empty: the byte goes to hold only; case 2/3/4 selection is unaffected in that cycle.

Decomposition:
- Package tx_pkg holds STUFF_LEN, IDLE_BIT, DATA_W defaults and the ones-counter width localparam $clog2(STUFF_LEN+1).
- Natural sub-module: tx_hold_buf, the one-entry holding register with valid/ready handshake. The rest stays flat in tx_stuff_serializer.

Test Plan:
- Send 0xA5, idle, ones_cnt=0 -> d_orig over 8 strobes = 1,0,1,0,0,1,0,1. byte_done after the 8th strobe; next strobe d_orig=1, idle=1.
- Send 0xFF -> six 1s, then a stuffed 0 with stuffing=1 on strobe 7, then 1,1. byte_done after strobe 9; final ones_cnt=2.
- Send 0xF0 then 0x3F back-to-back -> 0,0,0,0,1,1,1,1,1,1, stuff 0, then 1,1,1,1,0,0. 17 strobes with no gap; tx_ready low while hold is full.
- Send 0xFC and nothing else -> 0,0,1,1,1,1,1,1, then a trailing stuffed 0, then IDLE_BIT. idle is asserted only after the stuff bit.
- Assert rst after 3 bits of 0x55 with 0xAA held -> next cycle d_orig=1, tx_ready=1, idle=1. Then send 0x01 -> 1,0,0,0,0,0,0,0 with no stuffing carry-over.
- From idle with ones_cnt=4, assert clear_stuff, then send 0x03 -> no stuff bit is inserted. Assert clear_stuff mid-byte -> it is ignored.
